// File: rtl/write_sweep_sequencer.sv
// Write-sweep sequencer: walks an SRAM address range and hands one address/data
// pair per word to the write-cycle stage, waiting for its writing flag to rise and fall.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start_in; outputs parked at 0x1FF/0xFF
// ISSUE   | register address/data and pulse start_out
// WAIT_HI | waiting for writing_in to rise, with timeout
// WAIT_LO | waiting for writing_in to fall; word counted on the fall
// NEXT    | end of range or abort -> DONE, else advance address/LFSR
// DONE    | pulse done, drop busy, park outputs
module write_sweep_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  logic       abort_in,
    input  logic [8:0] addr_first,
    input  logic [8:0] addr_last,
    input  logic [1:0] pattern_sel,
    input  logic [7:0] seed,
    input  logic       writing_in,
    output logic       start_out,
    output logic [8:0] a_out,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [9:0] count_out
);

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] addr_q, addr_d;
    logic [8:0] last_q, last_d;
    logic [1:0] pat_q, pat_d;
    logic [7:0] seed_q, seed_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] tmo_q, tmo_d;
    logic [9:0] cnt_q, cnt_d;
    logic       abort_q, abort_d;
    logic       error_q, error_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       start_q, start_d;
    logic [8:0] a_q, a_d;
    logic [7:0] d_q, d_d;

    logic [7:0] pat_data;
    logic [7:0] lfsr_next;

    // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        pat_data = seed_q;
        case (pat_q)
            2'd0: pat_data = seed_q;
            2'd1: pat_data = addr_q[7:0] ^ seed_q;
            2'd2: pat_data = addr_q[0] ? ~seed_q : seed_q;
            2'd3: pat_data = lfsr_q;
            default: pat_data = seed_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            pat_q   <= '0;
            seed_q  <= '0;
            lfsr_q  <= 8'h01;
            tmo_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= 9'h1FF;
            d_q     <= 8'hFF;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            pat_q   <= pat_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            a_q     <= a_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        pat_d   = pat_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        error_d = error_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        start_d = 1'b0;
        a_d     = a_q;
        d_d     = d_q;

        // Abort is only remembered here; it is acted on in NEXT so a write is never cut short
        if (busy_q && abort_in) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    addr_d  = addr_first;
                    last_d  = addr_last;
                    pat_d   = pattern_sel;
                    seed_d  = seed;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    abort_d = 1'b0;
                    busy_d  = 1'b1;
                    if (pattern_sel == 2'd3) begin
                        lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                a_d     = addr_q;
                d_d     = pat_data;
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (writing_in) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TMO) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WAIT_LO: begin
                if (!writing_in) begin
                    cnt_d   = cnt_q + 10'd1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (addr_q == last_q || abort_q || abort_in) begin
                    state_d = S_DONE;
                end else begin
                    addr_d = addr_q + 9'd1;
                    if (pat_q == 2'd3) begin
                        lfsr_d = lfsr_next;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                abort_d = 1'b0;
                a_d     = 9'h1FF;
                d_d     = 8'hFF;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign start_out = start_q;
    assign a_out     = a_q;
    assign d_out     = d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign count_out = cnt_q;

endmodule

// File: tb/tb_write_sweep_sequencer.sv
// Directed bench for write_sweep_sequencer with a small write-cycle stage model
// (registered start, writing high for four cycles starting two cycles after start_out).
module tb_write_sweep_sequencer;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       start_in;
    logic       abort_in;
    logic [8:0] addr_first;
    logic [8:0] addr_last;
    logic [1:0] pattern_sel;
    logic [7:0] seed;
    logic       writing_in;
    logic       start_out;
    logic [8:0] a_out;
    logic [7:0] d_out;
    logic       busy;
    logic       done;
    logic       error;
    logic [9:0] count_out;

    int n_pass  = 0;
    int n_total = 0;

    write_sweep_sequencer #(.TIMEOUT(15)) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .start_in    (start_in),
        .abort_in    (abort_in),
        .addr_first  (addr_first),
        .addr_last   (addr_last),
        .pattern_sel (pattern_sel),
        .seed        (seed),
        .writing_in  (writing_in),
        .start_out   (start_out),
        .a_out       (a_out),
        .d_out       (d_out),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .count_out   (count_out)
    );

    always #5 clk_in = ~clk_in;

    // Write-cycle stage model
    logic       model_en;
    logic       st1;
    logic [2:0] wcnt;
    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            st1        <= 1'b0;
            writing_in <= 1'b0;
            wcnt       <= '0;
        end else begin
            st1 <= start_out & model_en;
            if (st1) begin
                writing_in <= 1'b1;
                wcnt       <= 3'd3;
            end else if (writing_in) begin
                if (wcnt == 3'd0) writing_in <= 1'b0;
                else wcnt <= wcnt - 3'd1;
            end
        end
    end

    // Monitor, sampled on the falling edge
    logic [8:0] log_a[$];
    logic [7:0] log_d[$];
    logic [8:0] cap_a;
    logic [7:0] cap_d;
    int cyc = 0, n_starts = 0, done_cnt = 0, stab_err = 0;
    int start_cyc = 0, err_cyc = -1, done_cyc = -1;
    logic err_prev = 1'b0;
    logic busy_at_done = 1'b1;
    always @(negedge clk_in) begin
        cyc++;
        if (start_out === 1'b1) begin
            log_a.push_back(a_out);
            log_d.push_back(d_out);
            n_starts++;
            start_cyc = cyc;
            cap_a = a_out;
            cap_d = d_out;
        end
        if (writing_in === 1'b1 && (a_out !== cap_a || d_out !== cap_d)) stab_err++;
        if (error === 1'b1 && err_prev !== 1'b1) err_cyc = cyc;
        err_prev = error;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    task automatic start_sweep(input logic [8:0] f, input logic [8:0] l,
                               input logic [1:0] p, input logic [7:0] s);
        @(negedge clk_in);
        addr_first  = f;
        addr_last   = l;
        pattern_sel = p;
        seed        = s;
        start_in    = 1'b1;
        log_a.delete();
        log_d.delete();
        n_starts = 0;
        done_cnt = 0;
        stab_err = 0;
        err_cyc  = -1;
        done_cyc = -1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk_in);
    endtask

    task automatic wait_write(input int nth, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (n_starts >= nth && writing_in === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        n_total++; if (start_out !== 1'b0) $display("FAIL reset_start_out: got %0b want 0", start_out); else n_pass++;
        n_total++; if (a_out !== 9'h1FF) $display("FAIL reset_a_out: got %h want 1ff", a_out); else n_pass++;
        n_total++; if (d_out !== 8'hFF) $display("FAIL reset_d_out: got %h want ff", d_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
        n_total++; if (error !== 1'b0) $display("FAIL reset_error: got %0b want 0", error); else n_pass++;
        n_total++; if (count_out !== 10'd0) $display("FAIL reset_count: got %0d want 0", count_out); else n_pass++;
    endtask

    task automatic test_constant;
        bit got;
        start_sweep(9'h010, 9'h013, 2'd0, 8'hA5);
        n_total++; if (busy !== 1'b1) $display("FAIL const_busy_rise: got %0b want 1", busy); else n_pass++;
        n_total++; if (start_out !== 1'b0) $display("FAIL const_start_latency: got %0b want 0", start_out); else n_pass++;
        @(negedge clk_in);
        n_total++; if (start_out !== 1'b1) $display("FAIL const_start_pulse: got %0b want 1", start_out); else n_pass++;
        n_total++; if (a_out !== 9'h010) $display("FAIL const_first_a: got %h want 010", a_out); else n_pass++;
        wait_done(200, got);
        n_total++; if (got !== 1'b1) $display("FAIL const_done_seen: got %0b want 1", got); else n_pass++;
        n_total++; if (n_starts !== 4) $display("FAIL const_nstarts: got %0d want 4", n_starts); else n_pass++;
        for (int i = 0; i < log_a.size() && i < 4; i++) begin
            n_total++; if (log_a[i] !== 9'(9'h010 + i)) $display("FAIL const_a[%0d]: got %h want %h", i, log_a[i], 9'(9'h010 + i)); else n_pass++;
            n_total++; if (log_d[i] !== 8'hA5) $display("FAIL const_d[%0d]: got %h want a5", i, log_d[i]); else n_pass++;
        end
        n_total++; if (count_out !== 10'd4) $display("FAIL const_count: got %0d want 4", count_out); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL const_done_pulses: got %0d want 1", done_cnt); else n_pass++;
        n_total++; if (error !== 1'b0) $display("FAIL const_error: got %0b want 0", error); else n_pass++;
        n_total++; if (busy_at_done !== 1'b0) $display("FAIL const_busy_at_done: got %0b want 0", busy_at_done); else n_pass++;
        n_total++; if (a_out !== 9'h1FF || d_out !== 8'hFF) $display("FAIL const_park: got %h/%h want 1ff/ff", a_out, d_out); else n_pass++;
        n_total++; if (stab_err !== 0) $display("FAIL const_stable: got %0d changes want 0", stab_err); else n_pass++;
    endtask

    task automatic test_wrap_xor;
        bit got;
        logic [8:0] ea[4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        logic [7:0] ed[4] = '{8'hF1, 8'hF0, 8'h0F, 8'h0E};
        start_sweep(9'h1FE, 9'h001, 2'd1, 8'h0F);
        wait_done(200, got);
        n_total++; if (got !== 1'b1) $display("FAIL wrap_done_seen: got %0b want 1", got); else n_pass++;
        n_total++; if (n_starts !== 4) $display("FAIL wrap_nstarts: got %0d want 4", n_starts); else n_pass++;
        for (int i = 0; i < log_a.size() && i < 4; i++) begin
            n_total++; if (log_a[i] !== ea[i]) $display("FAIL wrap_a[%0d]: got %h want %h", i, log_a[i], ea[i]); else n_pass++;
            n_total++; if (log_d[i] !== ed[i]) $display("FAIL wrap_d[%0d]: got %h want %h", i, log_d[i], ed[i]); else n_pass++;
        end
        n_total++; if (count_out !== 10'd4) $display("FAIL wrap_count: got %0d want 4", count_out); else n_pass++;
    endtask

    task automatic test_patterns;
        bit got;
        logic [7:0] e0[3] = '{8'h01, 8'h02, 8'h04};
        logic [7:0] e1[3] = '{8'h80, 8'h01, 8'h02};
        logic [7:0] e2[3] = '{8'hC3, 8'h3C, 8'hC3};
        start_sweep(9'h020, 9'h022, 2'd3, 8'h00);
        wait_done(200, got);
        n_total++; if (got !== 1'b1) $display("FAIL lfsr0_done_seen: got %0b want 1", got); else n_pass++;
        n_total++; if (n_starts !== 3) $display("FAIL lfsr0_nstarts: got %0d want 3", n_starts); else n_pass++;
        for (int i = 0; i < log_d.size() && i < 3; i++) begin
            n_total++; if (log_d[i] !== e0[i]) $display("FAIL lfsr0_d[%0d]: got %h want %h", i, log_d[i], e0[i]); else n_pass++;
        end
        n_total++; if (stab_err !== 0) $display("FAIL lfsr0_stable: got %0d changes want 0", stab_err); else n_pass++;
        n_total++; if (count_out !== 10'd3) $display("FAIL lfsr0_count: got %0d want 3", count_out); else n_pass++;

        start_sweep(9'h1FF, 9'h001, 2'd3, 8'h80);
        wait_done(200, got);
        n_total++; if (n_starts !== 3) $display("FAIL lfsr80_nstarts: got %0d want 3", n_starts); else n_pass++;
        for (int i = 0; i < log_d.size() && i < 3; i++) begin
            n_total++; if (log_d[i] !== e1[i]) $display("FAIL lfsr80_d[%0d]: got %h want %h", i, log_d[i], e1[i]); else n_pass++;
        end

        start_sweep(9'h005, 9'h007, 2'd2, 8'h3C);
        wait_done(200, got);
        n_total++; if (n_starts !== 3) $display("FAIL alt_nstarts: got %0d want 3", n_starts); else n_pass++;
        for (int i = 0; i < log_d.size() && i < 3; i++) begin
            n_total++; if (log_d[i] !== e2[i]) $display("FAIL alt_d[%0d]: got %h want %h", i, log_d[i], e2[i]); else n_pass++;
        end

        start_sweep(9'h0AA, 9'h0AA, 2'd0, 8'h5A);
        wait_done(200, got);
        n_total++; if (n_starts !== 1) $display("FAIL single_nstarts: got %0d want 1", n_starts); else n_pass++;
        n_total++; if (count_out !== 10'd1) $display("FAIL single_count: got %0d want 1", count_out); else n_pass++;
    endtask

    task automatic test_timeout;
        bit got;
        model_en = 1'b0;
        start_sweep(9'h000, 9'h005, 2'd0, 8'h11);
        wait_done(100, got);
        n_total++; if (got !== 1'b1) $display("FAIL tmo_done_seen: got %0b want 1", got); else n_pass++;
        n_total++; if (n_starts !== 1) $display("FAIL tmo_nstarts: got %0d want 1", n_starts); else n_pass++;
        n_total++; if (err_cyc - start_cyc !== 16) $display("FAIL tmo_error_delay: got %0d want 16", err_cyc - start_cyc); else n_pass++;
        n_total++; if (done_cyc - err_cyc !== 1) $display("FAIL tmo_done_delay: got %0d want 1", done_cyc - err_cyc); else n_pass++;
        n_total++; if (count_out !== 10'd0) $display("FAIL tmo_count: got %0d want 0", count_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL tmo_busy: got %0b want 0", busy); else n_pass++;
        repeat (10) @(negedge clk_in);
        n_total++; if (error !== 1'b1) $display("FAIL tmo_error_sticky: got %0b want 1", error); else n_pass++;
        model_en = 1'b1;
    endtask

    task automatic test_abort_restart;
        bit got;
        start_sweep(9'h100, 9'h109, 2'd0, 8'h77);
        n_total++; if (error !== 1'b0) $display("FAIL abort_error_cleared: got %0b want 0", error); else n_pass++;
        wait_write(2, 100, got);
        n_total++; if (got !== 1'b1) $display("FAIL abort_word2_seen: got %0b want 1", got); else n_pass++;
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in   = 1'b0;
        addr_first = 9'h000;
        addr_last  = 9'h003;
        start_in   = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_done(200, got);
        n_total++; if (got !== 1'b1) $display("FAIL abort_done_seen: got %0b want 1", got); else n_pass++;
        repeat (30) @(negedge clk_in);
        n_total++; if (count_out !== 10'd2) $display("FAIL abort_count: got %0d want 2", count_out); else n_pass++;
        n_total++; if (n_starts !== 2) $display("FAIL abort_nstarts: got %0d want 2", n_starts); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL abort_restart_ignored: got %0d done pulses want 1", done_cnt); else n_pass++;
        for (int i = 0; i < log_a.size() && i < 2; i++) begin
            n_total++; if (log_a[i] !== 9'(9'h100 + i)) $display("FAIL abort_a[%0d]: got %h want %h", i, log_a[i], 9'(9'h100 + i)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        int n_before;
        start_sweep(9'h050, 9'h05F, 2'd1, 8'h00);
        wait_write(2, 100, got);
        n_total++; if (got !== 1'b1) $display("FAIL rstmid_word2_seen: got %0b want 1", got); else n_pass++;
        @(negedge clk_in);
        #2 reset_in = 1'b1;
        #1;
        n_total++; if (a_out !== 9'h1FF || d_out !== 8'hFF) $display("FAIL rstmid_park: got %h/%h want 1ff/ff", a_out, d_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (count_out !== 10'd0) $display("FAIL rstmid_count: got %0d want 0", count_out); else n_pass++;
        @(negedge clk_in);
        reset_in = 1'b0;
        n_before = n_starts;
        repeat (40) @(negedge clk_in);
        n_total++; if (n_starts !== n_before) $display("FAIL rstmid_no_start: got %0d pulses want %0d", n_starts, n_before); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy_after: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_full_range;
        bit got;
        start_sweep(9'h000, 9'h1FF, 2'd1, 8'h00);
        wait_done(6000, got);
        n_total++; if (got !== 1'b1) $display("FAIL full_done_seen: got %0b want 1", got); else n_pass++;
        n_total++; if (count_out !== 10'd512) $display("FAIL full_count: got %0d want 512", count_out); else n_pass++;
        n_total++; if (n_starts !== 512) $display("FAIL full_nstarts: got %0d want 512", n_starts); else n_pass++;
        if (log_a.size() == 512) begin
            n_total++; if (log_a[256] !== 9'h100 || log_d[256] !== 8'h00) $display("FAIL full_mid: got %h/%h want 100/00", log_a[256], log_d[256]); else n_pass++;
            n_total++; if (log_a[511] !== 9'h1FF || log_d[511] !== 8'hFF) $display("FAIL full_last: got %h/%h want 1ff/ff", log_a[511], log_d[511]); else n_pass++;
        end
    endtask

    initial begin
        reset_in    = 1'b1;
        start_in    = 1'b0;
        abort_in    = 1'b0;
        addr_first  = '0;
        addr_last   = '0;
        pattern_sel = '0;
        seed        = '0;
        model_en    = 1'b1;
        test_reset();
        test_constant();
        test_wrap_xor();
        test_patterns();
        test_timeout();
        test_abort_restart();
        test_reset_mid();
        test_full_range();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
